// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment bus decoder:
// segment patterns (active-high, {g,f,e,d,c,b,a}), output codes and digit indices.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_6_ALT = 7'h7C;
    localparam logic [6:0] SEG_7_ALT = 7'h27;
    localparam logic [6:0] SEG_9_ALT = 7'h67;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef logic [1:0] dig_idx_t;

    localparam dig_idx_t DIG_UNITS     = 2'd0;
    localparam dig_idx_t DIG_TENS      = 2'd1;
    localparam dig_idx_t DIG_HUNDREDS  = 2'd2;
    localparam dig_idx_t DIG_THOUSANDS = 2'd3;

    // One registered bus sample after polarity normalisation (all active-high).
    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] digit;
    } sample_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic dig_idx_t onehot_to_idx(input logic [3:0] v);
        dig_idx_t idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = dig_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational inverse of the seven-segment encoder table: pattern {g..a} to
// 4-bit code, with an invalid flag for patterns no encoder produces.
module seg_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       invalid_o
);

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        code_o    = CODE_ERR;
        invalid_o = 1'b0;
        case (pattern_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_6_ALT: code_o = 4'd6;
            SEG_7_ALT: code_o = 4'd7;
            SEG_9_ALT: code_o = 4'd9;
            SEG_BLANK: code_o = CODE_BLANK;
            default: begin
                code_o    = CODE_ERR;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_seg_decoder.sv
// Monitors a multiplexed 4-digit seven-segment bus and recovers the displayed
// digits and decimal points once each digit pattern has been stable long enough.
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES    = 4,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SEG,
    input  logic [3:0] DIGIT,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic [3:0] dp,
    output logic       valid,
    output logic       frame_done,
    output logic       err
);

    localparam logic [7:0] SETTLE_TGT = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SEG_INV    = SEG_ACTIVE_LOW   ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_INV    = DIGIT_ACTIVE_LOW ? 4'hF  : 4'h0;

    logic [7:0]      seg_raw_q;
    logic [3:0]      digit_raw_q;
    sample_t         sample;
    sample_t         prev_q;
    logic [7:0]      cnt_q, cnt_d;
    logic            captured_q, captured_d;
    logic            selectable, same, capture;

    logic [3:0]      code;
    logic            invalid;
    dig_idx_t        idx;

    logic [3:0][3:0] digits_q, digits_d;
    logic [3:0]      dp_q, dp_d;
    logic [3:0]      mask_q, mask_d;
    logic            valid_q, valid_d;
    logic            frame_done_q, frame_done_d;
    logic            err_q, err_d;

    assign sample = {seg_raw_q ^ SEG_INV, digit_raw_q ^ DIG_INV};

    // ---------------------------------------------------------------------
    // Settle tracking: count consecutive identical samples, capture once per run.
    // ---------------------------------------------------------------------
    always_comb begin
        selectable = is_one_hot(sample.digit);
        same       = (sample == prev_q);
        cnt_d      = cnt_q;
        captured_d = captured_q;
        capture    = 1'b0;

        if (!selectable) begin
            cnt_d      = 8'd0;
            captured_d = 1'b0;
        end else begin
            if (same) begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_d      = 8'd1;
                captured_d = 1'b0;
            end
            if (cnt_d == SETTLE_TGT && !captured_d) begin
                capture    = 1'b1;
                captured_d = 1'b1;
            end
        end
    end

    // Reset deassertion is expected to arrive already synchronised to CLK.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_raw_q   <= '0;
            digit_raw_q <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            captured_q  <= 1'b0;
        end else begin
            seg_raw_q   <= SEG;
            digit_raw_q <= DIGIT;
            prev_q      <= sample;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
        end
    end

    // ---------------------------------------------------------------------
    // Decode and capture into the selected digit position.
    // ---------------------------------------------------------------------
    seg_to_bcd u_seg_to_bcd (
        .pattern_i (sample.seg[6:0]),
        .code_o    (code),
        .invalid_o (invalid)
    );

    assign idx = onehot_to_idx(sample.digit);

    always_comb begin
        digits_d     = digits_q;
        dp_d         = dp_q;
        mask_d       = mask_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;

        if (capture) begin
            digits_d[idx] = code;
            dp_d[idx]     = sample.seg[7];
            err_d         = invalid;
            mask_d        = mask_q | sample.digit;
            // Completing capture closes the frame; the next frame starts empty.
            if (mask_d == 4'hF) begin
                frame_done_d = 1'b1;
                valid_d      = 1'b1;
                mask_d       = 4'h0;
            end
        end
    end

    // NOTE: digit outputs are reset to the blank code because the reset value is observable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            digits_q     <= {4{CODE_BLANK}};
            dp_q         <= '0;
            mask_q       <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            dp_q         <= dp_d;
            mask_q       <= mask_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign units      = digits_q[DIG_UNITS];
    assign tens       = digits_q[DIG_TENS];
    assign hundreds   = digits_q[DIG_HUNDREDS];
    assign thousands  = digits_q[DIG_THOUSANDS];
    assign dp         = dp_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Scoreboard bench for seven_seg_decoder: a run-length model of the bus predicts
// every visible output change; a monitor compares value and edge of each change.
module tb_seven_seg_decoder;

    localparam int SETTLE = 4;

    typedef logic [22:0] snap_t;   // {thousands,hundreds,tens,units,dp,valid,frame_done,err}
    typedef struct {
        int    edge_no;
        snap_t snap;
    } exp_t;

    localparam snap_t RESET_SNAP = {16'hFFFF, 4'h0, 3'b000};

    localparam logic [6:0] REF_PAT [13] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                            7'h07, 7'h7F, 7'h6F, 7'h7C, 7'h27, 7'h67};
    localparam logic [3:0] REF_CODE [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                             4'd7, 4'd8, 4'd9, 4'd6, 4'd7, 4'd9};

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SEG;
    logic [3:0] DIGIT;
    logic [3:0] units, tens, hundreds, thousands, dp;
    logic       valid, frame_done, err;

    seven_seg_decoder #(
        .SETTLE_CYCLES    (SETTLE),
        .SEG_ACTIVE_LOW   (1'b1),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SEG        (SEG),
        .DIGIT      (DIGIT),
        .units      (units),
        .tens       (tens),
        .hundreds   (hundreds),
        .thousands  (thousands),
        .dp         (dp),
        .valid      (valid),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fd_cnt   = 0;
    int err_cnt  = 0;

    exp_t exp_q[$];

    // Behavioural model state
    logic [3:0]  m_code [4];
    logic [3:0]  m_dp, m_mask;
    logic        m_valid;
    logic [11:0] m_prev_pins;
    int          m_run;
    snap_t       m_last;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (frame_done) fd_cnt <= fd_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
        end
    end

    task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'h00) return {1'b0, 4'hF};
        for (int i = 0; i < 13; i++) begin
            if (REF_PAT[i] == p) return {1'b0, REF_CODE[i]};
        end
        return {1'b1, 4'hE};
    endfunction

    function automatic snap_t dut_snap();
        return {thousands, hundreds, tens, units, dp, valid, frame_done, err};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_code[i] = 4'hF;
        m_dp        = 4'h0;
        m_mask      = 4'h0;
        m_valid     = 1'b0;
        m_run       = 0;
        m_prev_pins = {8'hFF, 4'hF};
        m_last      = RESET_SNAP;
    endtask

    // Apply one cycle of pins and predict the outputs two edges later
    // (one edge to register the sample, one to capture it).
    task automatic drive(input logic [7:0] seg_pins, input logic [3:0] dig_pins);
        logic [7:0] sn;
        logic [3:0] dn;
        logic [4:0] dec;
        logic       fd, er;
        int         pos;
        snap_t      s;
        exp_t       e;
        @(posedge CLK);
        #1;
        SEG   = seg_pins;
        DIGIT = dig_pins;
        if ({seg_pins, dig_pins} == m_prev_pins) m_run++;
        else m_run = 1;
        m_prev_pins = {seg_pins, dig_pins};
        sn  = ~seg_pins;
        dn  = ~dig_pins;
        fd  = 1'b0;
        er  = 1'b0;
        pos = 0;
        if (m_run == SETTLE && $countones(dn) == 1) begin
            for (int i = 0; i < 4; i++) if (dn[i]) pos = i;
            dec         = ref_decode(sn[6:0]);
            m_code[pos] = dec[3:0];
            er          = dec[4];
            m_dp[pos]   = sn[7];
            m_mask[pos] = 1'b1;
            if (m_mask == 4'hF) begin
                fd      = 1'b1;
                m_valid = 1'b1;
                m_mask  = 4'h0;
            end
        end
        s = {m_code[3], m_code[2], m_code[1], m_code[0], m_dp, m_valid, fd, er};
        if (s != m_last) begin
            e.edge_no = cyc + 2;
            e.snap    = s;
            exp_q.push_back(e);
            m_last = s;
        end
    endtask

    task automatic hold(input logic [7:0] seg_pins, input logic [3:0] dig_pins, input int n);
        repeat (n) drive(seg_pins, dig_pins);
    endtask

    task automatic idle(input int n);
        hold(8'hFF, 4'hF, n);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        #1;
        RST   = 1'b1;
        SEG   = 8'hFF;
        DIGIT = 4'hF;
        exp_q.delete();
        model_reset();
        #1;
        check("rst_async_outputs", dut_snap() == RESET_SNAP, 32'(dut_snap()), 32'(RESET_SNAP));
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Monitor: every visible output change must match the next predicted change.
    initial begin : monitor
        snap_t prev, cur;
        exp_t  e;
        prev = RESET_SNAP;
        forever begin
            @(negedge CLK);
            cur = dut_snap();
            if (RST) begin
                prev = RESET_SNAP;
                continue;
            end
            if (cur != prev) begin
                check("change_expected", exp_q.size() > 0, 32'(cur), 32'(prev));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_value", cur == e.snap, 32'(cur), 32'(e.snap));
                    check("out_edge", cyc == e.edge_no, 32'(cyc), 32'(e.edge_no));
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int fd_base, err_base;
        logic [7:0] sp;
        logic [3:0] dg;
        RST   = 1'b0;
        SEG   = 8'hFF;
        DIGIT = 4'hF;
        model_reset();
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("reset_state", dut_snap() == RESET_SNAP, 32'(dut_snap()), 32'(RESET_SNAP));

        // Single digit capture with minimum settle time
        idle(2);
        hold(8'hC0, 4'b1110, 4);
        idle(3);
        check("t1_units", units == 4'd0, 32'(units), 32'd0);
        check("t1_others", {thousands, hundreds, tens} == 12'hFFF, 32'({thousands, hundreds, tens}), 32'hFFF);
        check("t1_valid", valid == 1'b0, 32'(valid), 32'd0);

        // Full frame 1,2,3,4
        fd_base = fd_cnt;
        hold(8'h99, 4'b1110, 8);
        hold(8'hB0, 4'b1101, 8);
        hold(8'hA4, 4'b1011, 8);
        hold(8'hF9, 4'b0111, 8);
        idle(3);
        check("t2_digits", {thousands, hundreds, tens, units} == 16'h1234,
              32'({thousands, hundreds, tens, units}), 32'h1234);
        check("t2_frame_once", fd_cnt - fd_base == 1, 32'(fd_cnt - fd_base), 32'd1);
        check("t2_valid", valid == 1'b1, 32'(valid), 32'd1);

        // Short glitch of 5 followed by a settled 0
        hold(8'h92, 4'b1101, 3);
        hold(8'hC0, 4'b1101, 4);
        idle(3);
        check("t3_tens", tens == 4'd0, 32'(tens), 32'd0);

        // Undecodable pattern
        err_base = err_cnt;
        hold(8'hAA, 4'b1011, 4);
        idle(3);
        check("t4_hundreds", hundreds == 4'hE, 32'(hundreds), 32'hE);
        check("t4_err_once", err_cnt - err_base == 1, 32'(err_cnt - err_base), 32'd1);

        // Two digits selected: ignored
        err_base = err_cnt;
        hold(8'hC0, 4'b1100, 10);
        idle(2);
        check("t5_no_err", err_cnt == err_base, 32'(err_cnt - err_base), 32'd0);

        // Reset mid-frame, then a fresh frame needs all four positions
        hold(8'hF8, 4'b1110, 5);
        hold(8'hF9, 4'b1101, 5);
        apply_reset();
        fd_base = fd_cnt;
        hold(8'h80, 4'b1110, 5);
        hold(8'h90, 4'b1101, 5);
        hold(8'h82, 4'b1011, 5);
        idle(3);
        check("t6_no_frame_yet", fd_cnt == fd_base, 32'(fd_cnt - fd_base), 32'd0);
        hold(8'h7F, 4'b0111, 5);
        idle(3);
        check("t6_frame", fd_cnt - fd_base == 1, 32'(fd_cnt - fd_base), 32'd1);
        check("t6_valid", valid == 1'b1, 32'(valid), 32'd1);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(99) < 85) dg = ~(4'b0001 << $urandom_range(3));
            else dg = 4'($urandom);
            if ($urandom_range(99) < 80) sp = ~{1'($urandom), REF_PAT[$urandom_range(12)]};
            else sp = 8'($urandom);
            hold(sp, dg, int'($urandom_range(1, 7)));
            if ($urandom_range(99) < 2) apply_reset();
        end

        idle(5);
        check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
